// File: rtl/rx_link_if.sv
// JESD204B receive-link bundle: decoded lane octets in, link status out.
// The controller takes the slave side; the lane/decoder side takes master.
interface rx_link_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int OCTETS = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] data_in;
  logic [OCTETS-1:0]     k_in;
  logic [OCTETS-1:0]     err_in;
  logic                  sync_n;
  logic                  en_data;
  logic [1:0]            state;
  logic [15:0]           err_count;

  modport master (
    output data_in, k_in, err_in,
    input  sync_n, en_data, state, err_count
  );

  modport slave (
    input  data_in, k_in, err_in,
    output sync_n, en_data, state, err_count
  );
endinterface

// File: rtl/rx_link_ctrl.sv
// JESD204B receive link controller: CGS -> ILAS_WAIT -> ILAS -> DATA bring-up,
// with ILAS timeout, error-run link drop and a saturating DATA error counter.
module rx_link_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int CGS_COUNT    = 4,
  parameter int ILAS_MF      = 4,
  parameter int ILAS_TIMEOUT = 256,
  parameter int ERR_THRESH   = 4
) (
  input  logic      clock,
  input  logic      reset,
  rx_link_if.slave  link
);
  localparam int OCTETS = DATA_WIDTH / 8;
  localparam int KW = $clog2(CGS_COUNT) + 1;
  localparam int TW = $clog2(ILAS_TIMEOUT) + 1;
  localparam int MW = $clog2(ILAS_MF) + 1;
  localparam int EW = $clog2(ERR_THRESH) + 1;

  // Counter values seen on the cycle whose increment would reach the limit.
  localparam logic [KW-1:0] K_LAST = KW'(CGS_COUNT - 1);
  localparam logic [TW-1:0] T_LAST = TW'(ILAS_TIMEOUT - 1);
  localparam logic [MW-1:0] M_LAST = MW'(ILAS_MF - 1);
  localparam logic [EW-1:0] E_LAST = EW'(ERR_THRESH - 1);

  localparam logic [7:0] CHAR_K = 8'hBC;
  localparam logic [7:0] CHAR_R = 8'h1C;
  localparam logic [7:0] CHAR_A = 8'h7C;

  typedef enum logic [1:0] {
    S_CGS       = 2'd0,
    S_ILAS_WAIT = 2'd1,
    S_ILAS      = 2'd2,
    S_DATA      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   kcnt_q, kcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [MW-1:0]   mfcnt_q, mfcnt_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [15:0]     err_count_q, err_count_d;

  logic all_k, errored, oct0_k, oct0_r, last_a;

  assign errored = |link.err_in;
  assign oct0_k  = link.k_in[0] && (link.data_in[7:0] == CHAR_K);
  assign oct0_r  = link.k_in[0] && (link.data_in[7:0] == CHAR_R);
  assign last_a  = link.k_in[OCTETS-1] &&
                   (link.data_in[(OCTETS-1)*8 +: 8] == CHAR_A);

  always_comb begin
    all_k = !errored;
    for (int i = 0; i < OCTETS; i++) begin
      if (!(link.k_in[i] && (link.data_in[i*8 +: 8] == CHAR_K))) all_k = 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    tmo_d       = tmo_q;
    mfcnt_d     = mfcnt_q;
    ecnt_d      = ecnt_q;
    err_count_d = err_count_q;

    case (state_q)
      S_CGS: begin
        if (!all_k)                kcnt_d  = '0;
        else if (kcnt_q == K_LAST) state_d = S_ILAS_WAIT;
        else                       kcnt_d  = kcnt_q + 1'b1;
      end
      S_ILAS_WAIT: begin
        if (errored)                          state_d = S_CGS;
        else if (oct0_r)                      state_d = (last_a && M_LAST == '0) ? S_DATA : S_ILAS;
        else if (!oct0_k || tmo_q == T_LAST)  state_d = S_CGS;
        else                                  tmo_d   = tmo_q + 1'b1;
      end
      S_ILAS: begin
        if (errored)                 state_d = S_CGS;
        else if (last_a) begin
          if (mfcnt_q == M_LAST)     state_d = S_DATA;
          else                       mfcnt_d = mfcnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (errored) begin
          if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
          if (ecnt_q == E_LAST)  state_d     = S_CGS;
          else                   ecnt_d      = ecnt_q + 1'b1;
        end else if (all_k) begin
          state_d = S_CGS;  // transmitter is re-initialising the link
        end else begin
          ecnt_d = '0;
        end
      end
      default: state_d = S_CGS;
    endcase

    // Every transition starts its counters afresh; ILAS entry may already
    // have consumed one multiframe if the R cycle also carried the A.
    if (state_d != state_q) begin
      kcnt_d  = '0;
      tmo_d   = '0;
      mfcnt_d = (state_d == S_ILAS) ? MW'(last_a) : '0;
      ecnt_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_CGS;
      kcnt_q      <= '0;
      tmo_q       <= '0;
      mfcnt_q     <= '0;
      ecnt_q      <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      tmo_q       <= tmo_d;
      mfcnt_q     <= mfcnt_d;
      ecnt_q      <= ecnt_d;
      err_count_q <= err_count_d;
    end
  end

  assign link.state     = state_q;
  assign link.sync_n    = (state_q != S_CGS);
  assign link.en_data   = (state_q == S_DATA);
  assign link.err_count = err_count_q;
endmodule

// File: tb/tb_rx_link_ctrl.sv
// Bench for rx_link_ctrl: directed bring-up/teardown scenarios, then random
// cycles, all checked against a cycle-count model of the link rules.
module tb_rx_link_ctrl;
  localparam int DW   = 64;
  localparam int OCT  = DW / 8;
  localparam int CGS  = 4;
  localparam int IMF  = 4;
  localparam int TMO  = 256;
  localparam int ETH  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rx_link_if #(.DATA_WIDTH(DW)) link ();

  rx_link_ctrl #(
    .DATA_WIDTH(DW), .CGS_COUNT(CGS), .ILAS_MF(IMF),
    .ILAS_TIMEOUT(TMO), .ERR_THRESH(ETH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .link  (link)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase number plus run lengths measured in cycles.
  int m_phase;        // 0 CGS, 1 ILAS_WAIT, 2 ILAS, 3 DATA
  int m_k_run;        // consecutive all-K cycles seen in CGS
  int m_wait_cycles;  // cycles spent in ILAS_WAIT
  int m_mf_done;      // multiframes completed in ILAS
  int m_err_run;      // consecutive errored cycles in DATA
  int m_err_total;

  function automatic void model_reset();
    m_phase = 0; m_k_run = 0; m_wait_cycles = 0;
    m_mf_done = 0; m_err_run = 0; m_err_total = 0;
  endfunction

  function automatic void enter(input int phase);
    m_phase = phase; m_k_run = 0; m_wait_cycles = 0;
    m_mf_done = 0; m_err_run = 0;
  endfunction

  function automatic void model_step(input logic [DW-1:0] d, input logic [OCT-1:0] k,
                                     input logic [OCT-1:0] e);
    bit is_all_k = (e == 0);
    bit is_err   = (e != 0);
    bit o0_r     = k[0] && d[7:0] == 8'h1C;
    bit o0_k     = k[0] && d[7:0] == 8'hBC;
    bit a_last   = k[OCT-1] && d[DW-8 +: 8] == 8'h7C;
    for (int i = 0; i < OCT; i++)
      if (!(k[i] && d[i*8 +: 8] == 8'hBC)) is_all_k = 0;
    case (m_phase)
      0: begin
        if (is_all_k) begin
          m_k_run++;
          if (m_k_run == CGS) enter(1);
        end else m_k_run = 0;
      end
      1: begin
        m_wait_cycles++;
        if (is_err) enter(0);
        else if (o0_r) begin
          enter(2);
          m_mf_done = a_last ? 1 : 0;
        end else if (!o0_k || m_wait_cycles == TMO) enter(0);
      end
      2: begin
        if (is_err) enter(0);
        else if (a_last) begin
          m_mf_done++;
          if (m_mf_done == IMF) enter(3);
        end
      end
      default: begin
        if (is_err) begin
          if (m_err_total < 65535) m_err_total++;
          m_err_run++;
          if (m_err_run == ETH) enter(0);
        end else if (is_all_k) enter(0);
        else m_err_run = 0;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [OCT-1:0] k, input logic [OCT-1:0] e);
    link.data_in = d;
    link.k_in    = k;
    link.err_in  = e;
    @(posedge clock);
    if (!reset) model_step(d, k, e);
    #1;
    check("model_state",     32'(link.state),     32'(m_phase));
    check("model_sync_n",    32'(link.sync_n),    32'(m_phase != 0));
    check("model_en_data",   32'(link.en_data),   32'(m_phase == 3));
    check("model_err_count", 32'(link.err_count), 32'(m_err_total));
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic send_allk();
    send({OCT{8'hBC}}, '1, '0);
  endtask

  task automatic send_r(input bit with_a);
    logic [DW-1:0]  d = rand_word();
    logic [OCT-1:0] k = '0;
    d[7:0] = 8'h1C; k[0] = 1'b1;
    if (with_a) begin d[DW-8 +: 8] = 8'h7C; k[OCT-1] = 1'b1; end
    send(d, k, '0);
  endtask

  task automatic send_a();
    logic [DW-1:0]  d = rand_word();
    logic [OCT-1:0] k = '0;
    d[DW-8 +: 8] = 8'h7C; k[OCT-1] = 1'b1;
    send(d, k, '0);
  endtask

  task automatic send_data();
    send(rand_word(), '0, '0);
  endtask

  task automatic send_err();
    send(rand_word(), '0, OCT'($urandom_range(1, (1 << OCT) - 1)));
  endtask

  initial begin
    model_reset();
    link.data_in = '0;
    link.k_in    = '0;
    link.err_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state",     32'(link.state),     0);
    check("reset_sync_n",    32'(link.sync_n),    0);
    check("reset_en_data",   32'(link.en_data),   0);
    check("reset_err_count", 32'(link.err_count), 0);

    // All-K present across an edge while reset is held must not count.
    link.data_in = {OCT{8'hBC}}; link.k_in = '1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("held_reset_state", 32'(link.state), 0);

    // CGS: a non-K cycle restarts the K run.
    repeat (3) send_allk();
    send_data();
    repeat (3) send_allk();
    check("cgs_run_restarted", 32'(link.state), 0);
    send_allk();
    check("cgs_exit_state",  32'(link.state),  1);
    check("cgs_exit_sync_n", 32'(link.sync_n), 1);

    // Full bring-up: R cycle without A, then four A cycles.
    repeat (2) send_allk();
    check("wait_hold_on_k", 32'(link.state), 1);
    send_r(1'b0);
    check("ilas_entry",         32'(link.state),   2);
    check("ilas_en_data_low",   32'(link.en_data), 0);
    repeat (3) send_a();
    check("ilas_after_3a",      32'(link.state),   2);
    send_a();
    check("data_entry",         32'(link.state),   3);
    check("data_en_data",       32'(link.en_data), 1);

    // Error run: 3 errored, 1 clean, 4 errored.
    repeat (3) send_err();
    check("data_after_3err", 32'(link.state), 3);
    send_data();
    repeat (3) send_err();
    check("data_run_restart", 32'(link.state),     3);
    check("err_count_six",    32'(link.err_count), 6);
    send_err();
    check("drop_state",     32'(link.state),     0);
    check("drop_sync_n",    32'(link.sync_n),    0);
    check("drop_en_data",   32'(link.en_data),   0);
    check("drop_err_count", 32'(link.err_count), 7);

    // R and A in one cycle: three more A cycles finish ILAS.
    repeat (4) send_allk();
    send_r(1'b1);
    check("ra_ilas", 32'(link.state), 2);
    repeat (2) send_a();
    check("ra_after_2a", 32'(link.state), 2);
    send_a();
    check("ra_data", 32'(link.state), 3);

    // All-K in DATA is a re-init request.
    send_allk();
    check("data_allk_reinit", 32'(link.state), 0);
    check("err_count_kept",   32'(link.err_count), 7);

    // ILAS_WAIT timeout with K only.
    repeat (4) send_allk();
    repeat (255) send_allk();
    check("tmo_before", 32'(link.state), 1);
    send_allk();
    check("tmo_state",  32'(link.state),  0);
    check("tmo_sync_n", 32'(link.sync_n), 0);

    // ILAS_WAIT abort on error and on an unexpected octet 0.
    repeat (4) send_allk();
    send_err();
    check("wait_err_abort", 32'(link.state), 0);
    repeat (4) send_allk();
    send_data();
    check("wait_data_abort", 32'(link.state), 0);

    // Asynchronous reset in the middle of an ILAS multiframe.
    repeat (4) send_allk();
    send_r(1'b0);
    send_a();
    check("pre_reset_ilas", 32'(link.state), 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_state",     32'(link.state),     0);
    check("async_sync_n",    32'(link.sync_n),    0);
    check("async_en_data",   32'(link.en_data),   0);
    check("async_err_count", 32'(link.err_count), 0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    check("post_reset_state", 32'(link.state), 0);

    // Random traffic, biased so the link regularly reaches DATA.
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 99);
      case (m_phase)
        0: if (r < 85) send_allk(); else if (r < 95) send_data(); else send_err();
        1: if (r < 60) send_allk(); else if (r < 90) send_r(r[0]);
           else if (r < 95) send_err(); else send_data();
        2: if (r < 55) send_a(); else if (r < 95) send_data(); else send_err();
        default: if (r < 55) send_data(); else if (r < 95) send_err(); else send_allk();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_link_ctrl.md
RX_LINK_CTRL -- requirements
Module: rx_link_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, decoded bits per cycle; OCTETS = DATA_WIDTH/8.
REQ-002 SHALL have parameter CGS_COUNT, default 4, consecutive all-/K/ cycles required to exit CGS.
REQ-003 SHALL have parameter ILAS_MF, default 4, ILAS multiframes (/A/-terminated) before DATA.
REQ-004 SHALL have parameter ILAS_TIMEOUT, default 256, max cycles in ILAS_WAIT before returning to CGS.
REQ-005 SHALL have parameter ERR_THRESH, default 4, consecutive errored DATA cycles that drop the link.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-008 data_in  input  DATA_WIDTH  decoded octets, octet i = data_in[i*8+:8], octet 0 first in time.
REQ-009 k_in  input  OCTETS  per-octet control-character flag from 8B10B decoders.
REQ-010 err_in  input  OCTETS  per-octet OR of code_err and disp_err.
REQ-011 sync_n  output  1  JESD204B SYNC~, low requests resynchronisation.
REQ-012 en_data  output  1  enable to descrambler and transport layer.
REQ-013 state  output  2  current state: 0 CGS, 1 ILAS_WAIT, 2 ILAS, 3 DATA.
REQ-014 err_count  output  16  saturating count of errored DATA cycles since reset.

Function
REQ-015 Definitions: K = octet 0xBC with k=1; R = 0x1C k=1; A = 0x7C k=1; all-K cycle = every octet K and err_in==0; errored cycle = any err_in bit set.
REQ-016 All outputs SHALL be registered; sync_n, en_data and state SHALL be decoded from the state register.
REQ-017 CGS: sync_n=0, en_data=0; counter kcnt increments on each all-K cycle, clears to 0 on any other cycle.
REQ-018 CGS -> ILAS_WAIT on the cycle kcnt would reach CGS_COUNT; sync_n high from the next cycle.
REQ-019 ILAS_WAIT: sync_n=1; all-K cycles hold state; tmo counter increments every cycle.
REQ-020 ILAS_WAIT -> ILAS when octet 0 is R and err_in==0; mfcnt set to 1 if octet OCTETS-1 of that cycle is A, else 0.
REQ-021 ILAS_WAIT -> CGS on: errored cycle, non-K non-R octet 0, or tmo reaching ILAS_TIMEOUT-1 without R.
REQ-022 ILAS: mfcnt increments on each cycle with octet OCTETS-1 == A; any errored cycle -> CGS.
REQ-023 ILAS -> DATA on the cycle mfcnt would reach ILAS_MF; en_data=1 from the next cycle (first data word is the cycle after the last A).
REQ-024 DATA: en_data=1, sync_n=1; ecnt increments on errored cycles, clears on clean cycles; err_count increments per errored cycle, saturating at 0xFFFF.
REQ-025 DATA -> CGS when ecnt would reach ERR_THRESH; en_data and sync_n low the next cycle.
REQ-026 DATA: an all-K cycle SHALL be treated as link re-init request by transmitter -> CGS.
REQ-027 kcnt, tmo, mfcnt, ecnt SHALL all clear on every state transition.
REQ-028 Counter widths SHALL be sized by $clog2 of their parameter +1; no wrap-around permitted.

Reset
REQ-029 On reset assertion (any time, including mid-ILAS/DATA): state=CGS, sync_n=0, en_data=0, err_count=0, all internal counters 0, within the same cycle (asynchronous).
REQ-030 After reset deassertion, first state change SHALL occur no earlier than the first rising edge.

Verification
REQ-031 Reset then 4 all-K cycles -> state=1, sync_n=1 on the cycle after the 4th; 3 all-K + 1 data cycle -> stays CGS, kcnt=0.
REQ-032 Full bring-up: 4 K, 2 K, R-start cycle, 4 cycles with octet 7 = 0x7C -> state=3, en_data=1 on the cycle after the 4th A.
REQ-033 R and A in the same cycle followed by 3 A cycles -> DATA entered after the 3rd additional A.
REQ-034 ILAS_WAIT with 256 all-K cycles and no R -> state=0, sync_n=0 on timeout.
REQ-035 In DATA: 3 errored, 1 clean, 4 errored cycles -> link drops only after the 4th consecutive; err_count=7.
REQ-036 Assert reset during ILAS mid-multiframe -> sync_n=0, en_data=0, state=0 immediately without a clock edge.
